// File: rtl/axi_pkg.sv
// Shared AXI crossbar definitions: master tags, slave indices, R-channel FSM
// states, routing targets, and the 3-way index increment.
package axi_pkg;

    // Master tag values carried in the upper bits of the slave-side ID
    localparam logic [3:0] MTAG_M0 = 4'b0001;
    localparam logic [3:0] MTAG_M1 = 4'b0010;

    // Slave index encoding
    localparam logic [1:0] SL_S0 = 2'd0;
    localparam logic [1:0] SL_S1 = 2'd1;
    localparam logic [1:0] SL_S2 = 2'd2;

    typedef enum logic {R_IDLE, R_LOCK} rstate_e;

    // Where the locked burst goes; T_DROP sinks beats with an unknown tag
    typedef enum logic [1:0] {T_M0, T_M1, T_DROP} tgt_e;

    // Next slave index modulo 3
    function automatic logic [1:0] next_slave(input logic [1:0] idx);
        return (idx >= SL_S2) ? SL_S0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rd_resp_router_rr_arb3.sv
// rr_arb3: combinational 3-way round-robin grant.
// Ports: req[2:0] request vector, rr_ptr first index to consider,
//        gnt_vld_c any request granted, gnt_idx_c granted slave index.
module rr_arb3
    import axi_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic       gnt_vld_c,
    output logic [1:0] gnt_idx_c
);

    // Request bit at a 2-bit slave index; index 3 never requests
    function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
        logic b;
        b = 1'b0;
        case (i)
            SL_S0:   b = r[0];
            SL_S1:   b = r[1];
            SL_S2:   b = r[2];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    logic [1:0] cand;

    // Scan rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first requester wins
    always_comb begin
        gnt_vld_c = 1'b0;
        gnt_idx_c = SL_S0;
        cand      = (rr_ptr > SL_S2) ? SL_S0 : rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_vld_c && req_at(req, cand)) begin
                gnt_vld_c = 1'b1;
                gnt_idx_c = cand;
            end
            cand = next_slave(cand);
        end
    end

endmodule

// File: rtl/rd_resp_router.sv
// rd_resp_router: AXI R-channel router. Arbitrates R bursts from S0/S1/S2
// round-robin, locks the winner until its RLAST handshake, and passes beats
// through to M0/M1 by the master tag in RID_Sx[IDS_W-1:ID_W]; unknown tags
// are sunk with drop_pulse.
// Ports: clk, rst (async, active-high); RID/RDATA/RRESP/RLAST/RVALID_Sx in,
//        RREADY_Sx out; RID/RDATA/RRESP/RLAST/RVALID_Mx out, RREADY_Mx in;
//        drop_pulse out.
module rd_resp_router
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned IDS_W  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDS_W-1:0]  RID_S0,
    input  logic [IDS_W-1:0]  RID_S1,
    input  logic [IDS_W-1:0]  RID_S2,
    input  logic [DATA_W-1:0] RDATA_S0,
    input  logic [DATA_W-1:0] RDATA_S1,
    input  logic [DATA_W-1:0] RDATA_S2,
    input  logic [1:0]        RRESP_S0,
    input  logic [1:0]        RRESP_S1,
    input  logic [1:0]        RRESP_S2,
    input  logic              RLAST_S0,
    input  logic              RLAST_S1,
    input  logic              RLAST_S2,
    input  logic              RVALID_S0,
    input  logic              RVALID_S1,
    input  logic              RVALID_S2,
    output logic              RREADY_S0,
    output logic              RREADY_S1,
    output logic              RREADY_S2,
    output logic [ID_W-1:0]   RID_M0,
    output logic [ID_W-1:0]   RID_M1,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M0,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M0,
    output logic              RLAST_M1,
    output logic              RVALID_M0,
    output logic              RVALID_M1,
    input  logic              RREADY_M0,
    input  logic              RREADY_M1,
    output logic              drop_pulse
);

    localparam int unsigned TAG_W = IDS_W - ID_W;

    rstate_e    state_q, state_d;
    logic [1:0] owner_q, owner_d;
    tgt_e       target_q, target_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;

    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic [TAG_W-1:0] gnt_tag;

    logic [ID_W-1:0]   own_id;
    logic [DATA_W-1:0] own_data;
    logic [1:0]        own_resp;
    logic              own_last;
    logic              own_valid;
    logic              rdy_c;
    logic              hs_c;

    function automatic tgt_e decode_tag(input logic [TAG_W-1:0] tag);
        tgt_e t;
        if (tag == TAG_W'(MTAG_M0))      t = T_M0;
        else if (tag == TAG_W'(MTAG_M1)) t = T_M1;
        else                             t = T_DROP;
        return t;
    endfunction

    rr_arb3 u_arb (
        .req       ({RVALID_S2, RVALID_S1, RVALID_S0}),
        .rr_ptr    (rr_ptr_q),
        .gnt_vld_c (gnt_vld),
        .gnt_idx_c (gnt_idx)
    );

    // Tag of the slave being granted this cycle
    always_comb begin
        gnt_tag = '0;
        case (gnt_idx)
            SL_S0:   gnt_tag = RID_S0[IDS_W-1:ID_W];
            SL_S1:   gnt_tag = RID_S1[IDS_W-1:ID_W];
            SL_S2:   gnt_tag = RID_S2[IDS_W-1:ID_W];
            default: gnt_tag = '0;
        endcase
    end

    // Beat currently presented by the locked owner
    always_comb begin
        own_id    = '0;
        own_data  = '0;
        own_resp  = '0;
        own_last  = 1'b0;
        own_valid = 1'b0;
        case (owner_q)
            SL_S0: begin
                own_id = RID_S0[ID_W-1:0]; own_data = RDATA_S0; own_resp = RRESP_S0;
                own_last = RLAST_S0; own_valid = RVALID_S0;
            end
            SL_S1: begin
                own_id = RID_S1[ID_W-1:0]; own_data = RDATA_S1; own_resp = RRESP_S1;
                own_last = RLAST_S1; own_valid = RVALID_S1;
            end
            SL_S2: begin
                own_id = RID_S2[ID_W-1:0]; own_data = RDATA_S2; own_resp = RRESP_S2;
                own_last = RLAST_S2; own_valid = RVALID_S2;
            end
            default: ;
        endcase
    end

    // Pass-through datapath; everything is zero outside LOCK, so reset
    // clears the handshake signals as soon as state_q falls to IDLE
    always_comb begin
        RID_M0 = '0; RDATA_M0 = '0; RRESP_M0 = '0; RLAST_M0 = 1'b0; RVALID_M0 = 1'b0;
        RID_M1 = '0; RDATA_M1 = '0; RRESP_M1 = '0; RLAST_M1 = 1'b0; RVALID_M1 = 1'b0;
        drop_pulse = 1'b0;
        rdy_c      = 1'b0;
        if (state_q == R_LOCK) begin
            case (target_q)
                T_M0: begin
                    RID_M0 = own_id; RDATA_M0 = own_data; RRESP_M0 = own_resp;
                    RLAST_M0 = own_last; RVALID_M0 = own_valid; rdy_c = RREADY_M0;
                end
                T_M1: begin
                    RID_M1 = own_id; RDATA_M1 = own_data; RRESP_M1 = own_resp;
                    RLAST_M1 = own_last; RVALID_M1 = own_valid; rdy_c = RREADY_M1;
                end
                default: begin
                    rdy_c      = 1'b1;
                    drop_pulse = own_valid;
                end
            endcase
        end
        hs_c      = own_valid & rdy_c;
        RREADY_S0 = rdy_c && (owner_q == SL_S0);
        RREADY_S1 = rdy_c && (owner_q == SL_S1);
        RREADY_S2 = rdy_c && (owner_q == SL_S2);
    end

    // Grant in IDLE, release after the owner's RLAST handshake
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            R_IDLE: begin
                if (gnt_vld) begin
                    state_d  = R_LOCK;
                    owner_d  = gnt_idx;
                    target_d = decode_tag(gnt_tag);
                end
            end
            R_LOCK: begin
                if (hs_c && own_last) begin
                    state_d  = R_IDLE;
                    rr_ptr_d = next_slave(owner_q);
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= R_IDLE;
            owner_q  <= SL_S0;
            target_q <= T_M0;
            rr_ptr_q <= SL_S0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_rd_resp_router.sv
// Directed testbench for rd_resp_router: per-cycle vector table for single
// burst, backpressure and invalid-tag bursts, plus hand sequences for
// round-robin, lock hold and asynchronous reset mid-burst.
module tb_rd_resp_router;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned IDS_W  = 8;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst;
    logic [IDS_W-1:0]  rid_s  [3];
    logic [DATA_W-1:0] data_s [3];
    logic [1:0]        resp_s [3];
    logic              last_s [3];
    logic              vld_s  [3];
    logic              rready_m0, rready_m1;

    logic              RREADY_S0, RREADY_S1, RREADY_S2;
    logic [ID_W-1:0]   RID_M0, RID_M1;
    logic [DATA_W-1:0] RDATA_M0, RDATA_M1;
    logic [1:0]        RRESP_M0, RRESP_M1;
    logic              RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
    logic              drop_pulse;

    int checks = 0;
    int errors = 0;

    rd_resp_router #(.ID_W(ID_W), .IDS_W(IDS_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .RID_S0(rid_s[0]), .RID_S1(rid_s[1]), .RID_S2(rid_s[2]),
        .RDATA_S0(data_s[0]), .RDATA_S1(data_s[1]), .RDATA_S2(data_s[2]),
        .RRESP_S0(resp_s[0]), .RRESP_S1(resp_s[1]), .RRESP_S2(resp_s[2]),
        .RLAST_S0(last_s[0]), .RLAST_S1(last_s[1]), .RLAST_S2(last_s[2]),
        .RVALID_S0(vld_s[0]), .RVALID_S1(vld_s[1]), .RVALID_S2(vld_s[2]),
        .RREADY_S0(RREADY_S0), .RREADY_S1(RREADY_S1), .RREADY_S2(RREADY_S2),
        .RID_M0(RID_M0), .RID_M1(RID_M1),
        .RDATA_M0(RDATA_M0), .RDATA_M1(RDATA_M1),
        .RRESP_M0(RRESP_M0), .RRESP_M1(RRESP_M1),
        .RLAST_M0(RLAST_M0), .RLAST_M1(RLAST_M1),
        .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
        .RREADY_M0(rready_m0), .RREADY_M1(rready_m1),
        .drop_pulse(drop_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sl;
        logic        v;
        logic [7:0]  rid;
        logic [31:0] data;
        logic        last;
        logic        rm0, rm1;
        logic        evm0, evm1;
        logic [2:0]  ers;
        logic [3:0]  eid;
        logic [31:0] edata;
        logic        elast;
        logic        edrop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int sl, logic v, logic [7:0] rid, logic [31:0] data, logic last,
                                logic rm0, logic rm1, logic evm0, logic evm1, logic [2:0] ers,
                                logic [3:0] eid, logic [31:0] edata, logic elast, logic edrop);
        vec_t t;
        t.sl = sl; t.v = v; t.rid = rid; t.data = data; t.last = last;
        t.rm0 = rm0; t.rm1 = rm1; t.evm0 = evm0; t.evm1 = evm1; t.ers = ers;
        t.eid = eid; t.edata = edata; t.elast = elast; t.edrop = edrop;
        return t;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h exp %0h", nm, idx, got, exp);
        end
    endtask

    task automatic set_slave(input int i, input logic v, input logic [7:0] id,
                             input logic [31:0] d, input logic l);
        vld_s[i]  = v;
        rid_s[i]  = v ? id : 8'h00;
        data_s[i] = v ? d : 32'h0;
        resp_s[i] = v ? d[1:0] : 2'b00;
        last_s[i] = v & l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rs_now();
        return 32'({RREADY_S2, RREADY_S1, RREADY_S0});
    endfunction

    task automatic chk_quiet(input string nm, input int idx);
        chk({nm, "_rvalid_m0"}, idx, 32'(RVALID_M0), 32'h0);
        chk({nm, "_rvalid_m1"}, idx, 32'(RVALID_M1), 32'h0);
        chk({nm, "_rready_s"}, idx, rs_now(), 32'h0);
    endtask

    task automatic check_vec(input int i, input vec_t t);
        chk("rvalid_m0", i, 32'(RVALID_M0), 32'(t.evm0));
        chk("rvalid_m1", i, 32'(RVALID_M1), 32'(t.evm1));
        chk("rready_s", i, rs_now(), 32'(t.ers));
        chk("drop_pulse", i, 32'(drop_pulse), 32'(t.edrop));
        chk("rid_m0", i, 32'(RID_M0), t.evm0 ? 32'(t.eid) : 32'h0);
        chk("rdata_m0", i, RDATA_M0, t.evm0 ? t.edata : 32'h0);
        chk("rresp_m0", i, 32'(RRESP_M0), t.evm0 ? 32'(t.edata[1:0]) : 32'h0);
        chk("rlast_m0", i, 32'(RLAST_M0), t.evm0 ? 32'(t.elast) : 32'h0);
        chk("rid_m1", i, 32'(RID_M1), t.evm1 ? 32'(t.eid) : 32'h0);
        chk("rdata_m1", i, RDATA_M1, t.evm1 ? t.edata : 32'h0);
        chk("rresp_m1", i, 32'(RRESP_M1), t.evm1 ? 32'(t.edata[1:0]) : 32'h0);
        chk("rlast_m1", i, 32'(RLAST_M1), t.evm1 ? 32'(t.elast) : 32'h0);
    endtask

    initial begin
        int order[4];
        order = '{0, 1, 2, 0};
        for (int i = 0; i < 3; i++) set_slave(i, 1'b0, 8'h00, 32'h0, 1'b0);
        rready_m0 = 1'b0;
        rready_m1 = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Single burst S0 -> M0 (rr_ptr 0 -> 1)
        vecs.push_back(mk(0, 1, 8'h13, 32'hA0, 0, 1, 0, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 32'hA0, 0, 1, 0, 1, 0, 3'b001, 4'h3, 32'hA0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 32'hA1, 0, 1, 0, 1, 0, 3'b001, 4'h3, 32'hA1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 32'hA2, 0, 1, 0, 1, 0, 3'b001, 4'h3, 32'hA2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 32'hA3, 1, 1, 0, 1, 0, 3'b001, 4'h3, 32'hA3, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 32'h00, 0, 1, 0, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));
        // Backpressure S1 -> M1, M1 ready 1,0,0,1,1 (rr_ptr -> 2)
        vecs.push_back(mk(1, 1, 8'h25, 32'hB0, 0, 1, 1, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));
        vecs.push_back(mk(1, 1, 8'h25, 32'hB0, 0, 1, 1, 0, 1, 3'b010, 4'h5, 32'hB0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h25, 32'hB1, 0, 1, 0, 0, 1, 3'b000, 4'h5, 32'hB1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h25, 32'hB1, 0, 1, 0, 0, 1, 3'b000, 4'h5, 32'hB1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h25, 32'hB1, 0, 1, 1, 0, 1, 3'b010, 4'h5, 32'hB1, 0, 0));
        vecs.push_back(mk(1, 1, 8'h25, 32'hB2, 1, 1, 1, 0, 1, 3'b010, 4'h5, 32'hB2, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 32'h00, 0, 1, 1, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));
        // Invalid tag on S2: sunk with drop_pulse (rr_ptr -> 0)
        vecs.push_back(mk(2, 1, 8'h71, 32'hC0, 0, 1, 1, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));
        vecs.push_back(mk(2, 1, 8'h71, 32'hC0, 0, 1, 1, 0, 0, 3'b100, 4'h0, 32'h00, 0, 1));
        vecs.push_back(mk(2, 1, 8'h71, 32'hC1, 1, 1, 1, 0, 0, 3'b100, 4'h0, 32'h00, 0, 1));
        vecs.push_back(mk(2, 0, 8'h00, 32'h00, 0, 1, 1, 0, 0, 3'b000, 4'h0, 32'h00, 0, 0));

        // Reset state
        @(negedge clk);
        chk_quiet("reset", 0);
        chk("reset_drop", 0, 32'(drop_pulse), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset_idle", 0);
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            for (int s = 0; s < 3; s++) set_slave(s, 1'b0, 8'h00, 32'h0, 1'b0);
            set_slave(vecs[i].sl, vecs[i].v, vecs[i].rid, vecs[i].data, vecs[i].last);
            rready_m0 = vecs[i].rm0;
            rready_m1 = vecs[i].rm1;
            @(negedge clk);
            check_vec(i, vecs[i]);
            tick();
        end

        // Round-robin: all three single-beat requests at once, S0 re-raised
        rready_m0 = 1'b1;
        rready_m1 = 1'b1;
        set_slave(0, 1'b1, 8'h10, 32'h100, 1'b1);
        set_slave(1, 1'b1, 8'h20, 32'h101, 1'b1);
        set_slave(2, 1'b1, 8'h11, 32'h102, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_idle_rready_s", k, rs_now(), 32'h0);
            tick();
            @(negedge clk);
            chk("rr_grant_rready_s", k, rs_now(), 32'(1) << order[k]);
            if (order[k] == 1) begin
                chk("rr_rvalid_m1", k, 32'(RVALID_M1), 32'h1);
                chk("rr_rvalid_m0", k, 32'(RVALID_M0), 32'h0);
                chk("rr_rdata_m1", k, RDATA_M1, 32'h101);
            end else begin
                chk("rr_rvalid_m0", k, 32'(RVALID_M0), 32'h1);
                chk("rr_rvalid_m1", k, 32'(RVALID_M1), 32'h0);
                chk("rr_rdata_m0", k, RDATA_M0, 32'h100 + 32'(order[k]));
            end
            tick();
            set_slave(order[k], 1'b0, 8'h00, 32'h0, 1'b0);
            if (k == 1) set_slave(0, 1'b1, 8'h10, 32'h100, 1'b1);
        end

        // Lock hold: S2 waits through an S0 burst (rr_ptr 1, S1 idle)
        set_slave(0, 1'b1, 8'h12, 32'hD0, 1'b0);
        @(negedge clk);
        chk("hold_idle_rready_s", 0, rs_now(), 32'h0);
        tick();
        set_slave(2, 1'b1, 8'h21, 32'hE5, 1'b1);
        @(negedge clk);
        chk("hold_rready_s", 1, rs_now(), 32'h1);
        chk("hold_rdata_m0", 1, RDATA_M0, 32'hD0);
        tick();
        set_slave(0, 1'b1, 8'h12, 32'hD1, 1'b0);
        @(negedge clk);
        chk("hold_rready_s", 2, rs_now(), 32'h1);
        tick();
        set_slave(0, 1'b1, 8'h12, 32'hD2, 1'b1);
        @(negedge clk);
        chk("hold_rready_s", 3, rs_now(), 32'h1);
        chk("hold_rlast_m0", 3, 32'(RLAST_M0), 32'h1);
        tick();
        set_slave(0, 1'b0, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        chk_quiet("hold_gap", 4);
        tick();
        @(negedge clk);
        chk("hold_s2_rready_s", 5, rs_now(), 32'h4);
        chk("hold_s2_rvalid_m1", 5, 32'(RVALID_M1), 32'h1);
        chk("hold_s2_rid_m1", 5, 32'(RID_M1), 32'h1);
        chk("hold_s2_rdata_m1", 5, RDATA_M1, 32'hE5);
        tick();
        set_slave(2, 1'b0, 8'h00, 32'h0, 1'b0);

        // Move rr_ptr to 2 with a single S1 beat so the reset value matters
        set_slave(1, 1'b1, 8'h25, 32'hF8, 1'b1);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("pre_rst_rready_s", 0, rs_now(), 32'h2);
        tick();
        set_slave(1, 1'b0, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        tick();

        // Reset on the 2nd beat of a 4-beat S0 burst
        set_slave(0, 1'b1, 8'h13, 32'hF0, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rst_burst_beat0", 0, 32'(RVALID_M0), 32'h1);
        tick();
        set_slave(0, 1'b1, 8'h13, 32'hF1, 1'b0);
        #2;
        chk("rst_burst_beat1", 1, 32'(RVALID_M0), 32'h1);
        rst = 1'b1;
        #1;
        chk_quiet("rst_async", 0);
        @(negedge clk);
        chk_quiet("rst_held", 0);
        tick();
        set_slave(0, 1'b0, 8'h00, 32'h0, 1'b0);
        set_slave(1, 1'b1, 8'h25, 32'h55, 1'b1);
        set_slave(2, 1'b1, 8'h16, 32'h66, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_release_idle", 0);
        tick();
        @(negedge clk);
        chk("rst_s1_rready_s", 0, rs_now(), 32'h2);
        chk("rst_s1_rvalid_m1", 0, 32'(RVALID_M1), 32'h1);
        chk("rst_s1_rid_m1", 0, 32'(RID_M1), 32'h5);
        chk("rst_s1_rvalid_m0", 0, 32'(RVALID_M0), 32'h0);
        tick();
        set_slave(1, 1'b0, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        chk_quiet("rst_gap", 1);
        tick();
        @(negedge clk);
        chk("rst_s2_rready_s", 1, rs_now(), 32'h4);
        chk("rst_s2_rid_m0", 1, 32'(RID_M0), 32'h6);
        tick();
        set_slave(2, 1'b0, 8'h00, 32'h0, 1'b0);
        @(negedge clk);
        chk_quiet("end_idle", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
